// File: rtl/bram_stream_reader_if.sv
// Output stream of the BRAM burst reader: data/valid from the reader, ready back.
//   m_data  - stream word (FIFO head)
//   m_valid - word available
//   m_ready - downstream accepts; transfer when m_valid && m_ready
interface bram_stream_reader_if #(
    parameter int unsigned WIDTH = 3
) ();
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/bram_stream_reader.sv
// Reads a burst of consecutive BRAM words and streams them out through a small
// FIFO, issuing addresses only when the FIFO is guaranteed to have room.
//   clk, rst              - clock, async active-high reset
//   start/base_addr/length- burst request (sampled in IDLE only)
//   busy, done            - burst in progress / one-cycle completion pulse
//   bram_*                - read-only BRAM port (fixed latency RD_LAT)
//   m_axis                - output stream (master side)
module bram_stream_reader #(
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       base_addr,
    input  logic [15:0]       length,
    output logic              busy,
    output logic              done,
    output logic [15:0]       bram_addr,
    output logic              bram_clk,
    output logic [WIDTH-1:0]  bram_din,
    output logic              bram_wea,
    input  logic [WIDTH-1:0]  bram_dout,
    bram_stream_reader_if.master m_axis
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                issue_q;          // bram_addr carries a live read this cycle
    logic [RD_LAT-1:0]   tag_q;            // reads waiting for their data
    logic [15:0]         next_addr_q;
    logic [15:0]         issue_left_q;     // addresses still to issue
    logic [15:0]         words_left_q;     // words still to hand downstream

    logic [WIDTH-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                valid_q;

    logic                push_c, pop_c, issue_c, load_c, room_c;
    logic [OCC_W-1:0]    in_flight_c, occ_c;
    logic [15:0]         issue_addr_c;

    assign bram_clk       = clk;
    assign bram_din       = '0;
    assign bram_wea       = 1'b0;
    assign m_axis.m_data  = fifo_mem[rd_ptr_q];
    assign m_axis.m_valid = valid_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy bookkeeping: the pop committed this cycle frees a slot,
    // which keeps back-to-back issue possible with FIFO_DEPTH = RD_LAT+2.
    always_comb begin
        push_c      = tag_q[RD_LAT-1];
        pop_c       = valid_q && m_axis.m_ready;
        in_flight_c = OCC_W'(issue_q);
        for (int i = 0; i < int'(RD_LAT); i++) begin
            in_flight_c = in_flight_c + OCC_W'(tag_q[i]);
        end
        occ_c   = OCC_W'(count_q) + in_flight_c - OCC_W'(pop_c);
        room_c  = occ_c < OCC_W'(FIFO_DEPTH);
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // Next-state and issue decision
    always_comb begin
        state_d      = state_q;
        issue_c      = 1'b0;
        load_c       = 1'b0;
        issue_addr_c = next_addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != 16'd0) begin
                        load_c       = 1'b1;
                        issue_c      = 1'b1;
                        issue_addr_c = base_addr;
                        state_d      = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (issue_left_q == 16'd0) begin
                    state_d = S_DRAIN;
                end else if (room_c) begin
                    issue_c = 1'b1;
                end
            end
            S_DRAIN: begin
                if (pop_c && (words_left_q == 16'd1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers and address generator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            bram_addr    <= 16'd0;
            issue_q      <= 1'b0;
            tag_q        <= '0;
            next_addr_q  <= 16'd0;
            issue_left_q <= 16'd0;
            words_left_q <= 16'd0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done    <= (state_d == S_DONE);
            issue_q <= issue_c;
            tag_q[0] <= issue_q;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (issue_c) begin
                bram_addr   <= issue_addr_c;
                next_addr_q <= issue_addr_c + 16'd1;
            end
            if (load_c) begin
                issue_left_q <= length - 16'd1;
                words_left_q <= length;
            end else begin
                if (issue_c) issue_left_q <= issue_left_q - 16'd1;
                if (pop_c)   words_left_q <= words_left_q - 16'd1;
            end
        end
    end

    // Output FIFO; the issue rule guarantees a push never finds it full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push_c) begin
                fifo_mem[wr_ptr_q] <= bram_dout;
                wr_ptr_q           <= ptr_inc(wr_ptr_q);
            end
            if (pop_c) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

endmodule
